// File: rtl/io64_uart_tx_pkg.sv
// Shared types and constants for the IO address 64 UART transmitter.
package io64_pkg;

    localparam logic [7:0] IO64_ADDR = 8'h40;
    localparam int         DATA_W    = 16;
    localparam int         BYTE_W    = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_PARITY
    } tx_state_e;

endpackage

// File: rtl/io64_uart_tx_if.sv
// Write-back side port: the IO address 64 write strobe and its data word.
interface io64_uart_tx_if;
    import io64_pkg::*;

    logic              IO_WEN;
    logic [DATA_W-1:0] IO_DATA;

    modport master (output IO_WEN, output IO_DATA);
    modport slave  (input  IO_WEN, input  IO_DATA);

endinterface

// File: rtl/io64_word_fifo.sv
// Word capture FIFO; a push while full is dropped and latches a sticky overrun flag.
module io64_word_fifo
    import io64_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign overrun = overrun_q;
    assign rdata   = mem[rd_ptr_q];

    // A same-cycle pop frees a slot, so a full FIFO can still accept the write.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        overrun_d = overrun_q || (push && !do_push);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/io64_uart_tx.sv
// Serialises words written to IO address 64 as two UART bytes, low byte first.
// Define IO64_TX_PARITY_EN for 8E1 framing; default build is 8N1.
module io64_uart_tx
    import io64_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    io64_uart_tx_if.slave  bus,
    output logic           TXD,
    output logic           BUSY,
    output logic           FULL,
    output logic           OVERRUN
);

    localparam logic [15:0] TMR_LOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_sel_q, byte_sel_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              txd_q, txd_d;

    logic              fifo_pop, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [BYTE_W-1:0] cur_byte;
    logic              tick;

    io64_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (bus.IO_WEN),
        .wdata   (bus.IO_DATA),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (FULL),
        .empty   (fifo_empty),
        .overrun (OVERRUN)
    );

    assign cur_byte = byte_sel_q ? hold_q[DATA_W-1:BYTE_W] : hold_q[BYTE_W-1:0];
    assign tick     = (timer_q == '0);
    assign fifo_pop = (state_q == TX_IDLE) && !fifo_empty;
    assign TXD      = txd_q;
    assign BUSY     = !fifo_empty || (state_q != TX_IDLE);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        hold_d     = hold_q;
        if (state_q != TX_IDLE && !tick) timer_d = timer_q - 16'd1;

        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    hold_d     = fifo_rdata;
                    byte_sel_d = 1'b0;
                    timer_d    = TMR_LOAD;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    bit_idx_d = 3'd0;
                    timer_d   = TMR_LOAD;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    timer_d = TMR_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef IO64_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef IO64_TX_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    timer_d = TMR_LOAD;
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    // High byte follows the low byte's stop bit with no idle gap.
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        timer_d    = TMR_LOAD;
                        state_d    = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Line level follows the current state one clock later, straight from a flop.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = cur_byte[bit_idx_q];
`ifdef IO64_TX_PARITY_EN
            TX_PARITY: txd_d = ^cur_byte;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= TX_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            txd_q      <= txd_d;
        end
    end

    always_ff @(posedge CLK) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_io64_uart_tx.sv
// Scoreboard bench for io64_uart_tx: a UART decoder on TXD checks bytes, framing and inter-frame gaps.
`timescale 1ns/1ps
module tb_io64_uart_tx;
    import io64_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef IO64_TX_PARITY_EN
    localparam int FRAME_CYC = 22 * CPB;
`else
    localparam int FRAME_CYC = 20 * CPB;
`endif

    typedef struct {
        logic [7:0] b;
        logic       par;
        int         gap;
    } exp_t;

    logic CLK;
    logic RESET;
    logic TXD, BUSY, FULL, OVERRUN;

    io64_uart_tx_if bus_if ();

    io64_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus_if),
        .TXD     (TXD),
        .BUSY    (BUSY),
        .FULL    (FULL),
        .OVERRUN (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t scb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_busy = 1'b0;
    logic mon_aborted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bytes go to the scoreboard; gap -1 means the preceding idle length is free.
    task automatic push_word(input logic [15:0] w, input int gap0);
        scb.push_back('{b: w[7:0],  par: ^w[7:0],  gap: gap0});
        scb.push_back('{b: w[15:8], par: ^w[15:8], gap: CPB});
    endtask

    // Called #1 after an edge; the strobe is sampled on the next edge and the call returns #1 after it.
    task automatic do_write(input logic [15:0] w, input bit expect_tx, input int gap0);
        bus_if.IO_WEN  = 1'b1;
        bus_if.IO_DATA = w;
        if (expect_tx) push_word(w, gap0);
        @(posedge CLK); #1;
        bus_if.IO_WEN  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((scb.size() != 0 || mon_busy || BUSY) && k < budget) begin
            @(posedge CLK); #1;
            k++;
        end
        check("drain_in_time", 32'(k < budget), 32'd1);
    endtask

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (RESET) mon_aborted = 1'b1;
        end
    endtask

    // Decoder: sample each bit at its midpoint; high-run length before a start bit is the idle gap.
    initial begin : monitor
        int         hi_run;
        int         got_gap;
        logic [7:0] rx;
        logic       start_s, stop_s, par_s;
        exp_t       e;
        hi_run = 0;
        par_s  = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                hi_run = 0;
            end else if (TXD === 1'b1) begin
                hi_run++;
            end else begin
                mon_busy    = 1'b1;
                mon_aborted = 1'b0;
                got_gap     = hi_run;
                mon_wait(CPB / 2);
                start_s = TXD;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB);
                    rx[i] = TXD;
                end
`ifdef IO64_TX_PARITY_EN
                mon_wait(CPB);
                par_s = TXD;
`endif
                mon_wait(CPB);
                stop_s = TXD;
                if (!mon_aborted) begin
                    if (scb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, expected no frame at %0t", rx, $time);
                    end else begin
                        e = scb.pop_front();
                        check("rx_byte", 32'(rx), 32'(e.b));
                        check("start_bit", 32'(start_s), 32'd0);
                        check("stop_bit", 32'(stop_s), 32'd1);
                        if (e.gap >= 0) check("idle_gap", 32'(got_gap), 32'(e.gap));
`ifdef IO64_TX_PARITY_EN
                        check("parity_bit", 32'(par_s), 32'(e.par));
`endif
                    end
                end
                hi_run   = CPB / 2 + 1;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        RESET          = 1'b1;
        bus_if.IO_WEN  = 1'b0;
        bus_if.IO_DATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_state", {28'd0, TXD, BUSY, FULL, OVERRUN}, 32'b1000);
        RESET = 1'b0;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            check("idle_outputs", {28'd0, TXD, BUSY, FULL, OVERRUN}, 32'b1000);
        end

        // Single word: start bit appears two edges after the strobe edge
        do_write(16'hA55A, 1'b1, -1);
        check("busy_after_write", 32'(BUSY), 32'd1);
        @(posedge CLK); #1;
        check("txd_high_n1", 32'(TXD), 32'd1);
        @(posedge CLK); #1;
        check("txd_start_n2", 32'(TXD), 32'd0);
        k = 0;
        while (BUSY && k < 400) begin
            @(posedge CLK); #1;
            k++;
        end
        // FSM returns to IDLE one edge before the last stop-bit cycle leaves TXD.
        check("word_frame_len", 32'(k), 32'(FRAME_CYC - 1));
        check("txd_idle_after", 32'(TXD), 32'd1);
        wait_done(200);

        // Back-to-back words: one idle-high cycle between words
        do_write(16'h0001, 1'b1, -1);
        do_write(16'h8000, 1'b1, CPB + 1);
        do_write(16'hFFFF, 1'b1, CPB + 1);
        wait_done(1000);

        // Overflow: sixth write lands while full and is dropped
        do_write(16'h2211, 1'b1, -1);
        do_write(16'h4433, 1'b1, CPB + 1);
        do_write(16'h6655, 1'b1, CPB + 1);
        do_write(16'h8877, 1'b1, CPB + 1);
        check("full_after_w4", 32'(FULL), 32'd0);
        do_write(16'hAA99, 1'b1, CPB + 1);
        check("full_after_w5", 32'(FULL), 32'd1);
        check("overrun_after_w5", 32'(OVERRUN), 32'd0);
        do_write(16'hCCBB, 1'b0, -1);
        check("full_after_w6", 32'(FULL), 32'd1);
        check("overrun_after_w6", 32'(OVERRUN), 32'd1);
        wait_done(2000);
        check("overrun_sticky", 32'(OVERRUN), 32'd1);
        check("full_drained", 32'(FULL), 32'd0);

        // Reset during data bit 3 of the first byte, with a second word queued
        do_write(16'hBEA5, 1'b0, -1);
        do_write(16'h5555, 1'b0, -1);
        repeat (17) @(posedge CLK);
        #1;
        check("pre_reset_bit3", 32'(TXD), 32'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("reset_abort", {28'd0, TXD, BUSY, FULL, OVERRUN}, 32'b1000);
        RESET = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            check("quiet_after_reset", {30'd0, TXD, BUSY}, 32'b10);
        end
        do_write(16'h1234, 1'b1, -1);
        wait_done(400);

`ifdef IO64_TX_PARITY_EN
        // 8E1: 0x03 has even ones (parity 0), 0x07 odd ones (parity 1)
        do_write(16'h0703, 1'b1, -1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("par_txd_start", 32'(TXD), 32'd0);
        k = 0;
        while (BUSY && k < 400) begin
            @(posedge CLK); #1;
            k++;
        end
        check("par_frame_len", 32'(k), 32'd87);
        wait_done(200);
`endif

        repeat (10) @(posedge CLK);
        #1;
        check("scb_empty_end", 32'(scb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
